layer_stream_bridge: RTL

Parametrised layer-to-layer serializer for the MNIST accelerator datapath. Captures the parallel output vector of one neuron layer when the layer's valid fires and streams it one neuron value per beat into the next layer or the max finder. Uses a valid/ready handshake with backpressure, an exact beat count, a last-beat marker, optional ping-pong double buffering, and drop accounting. Replaces the per-layer hand-written IDLE/SEND serializers in the top level.

---
 rtl/layer_stream_bridge_pkg.sv | 28 ++
 rtl/layer_stream_bridge_vec_shift_buf.sv | 39 +++
 rtl/layer_stream_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_stream_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_stream_bridge_pkg
// Description : Shared constants for the layer-to-layer stream bridge.
//               Holds the default layer geometry used at instantiation, the
//               per-slot state encoding and a beat-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_stream_bridge_pkg;

    // Default geometry of a neuron layer vector
    localparam int c_DATA_WIDTH         = 16;
    localparam int c_NUM_NEURON_LAYER_N = 30;

    // Lifecycle of one vector slot
    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_FULL    = 2'd1,
        SLOT_SENDING = 2'd2
    } slot_state_t;

    // Beat index width, never below one bit so NN=1 still has a counter
    function automatic int beat_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_stream_bridge_vec_shift_buf.sv
`default_nettype none
// ============================================================================
// Module      : vec_shift_buf
// Description : One NN*DATA_WIDTH vector slot. Loads a whole vector, shifts
//               down by one element per accepted beat and exposes the lowest
//               element as the head value.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_shift_buf
    import layer_stream_bridge_pkg::*;
#(
    parameter int NN         = c_NUM_NEURON_LAYER_N,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load,
    input  logic [NN*DATA_WIDTH-1:0]   i_load_data,
    input  logic                       i_shift,
    output logic [DATA_WIDTH-1:0]      o_head
);

    logic [NN*DATA_WIDTH-1:0] r_data;

    // Vector storage: load wins over shift, shift drops the head element
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift) begin
            r_data <= r_data >> DATA_WIDTH;
        end
    end

    assign o_head = r_data[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/layer_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module      : layer_stream_bridge
// Description : Captures a parallel layer vector on in_valid and streams it
//               one element per beat over a valid/ready interface, with a
//               last-beat marker and saturating drop accounting.
//               Optional macro LAYER_BRIDGE_PINGPONG_EN selects two vector
//               slots (ping-pong); otherwise a single slot is built.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_stream_bridge
    import layer_stream_bridge_pkg::*;
#(
    parameter int NN         = c_NUM_NEURON_LAYER_N,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       wb_rst_i,
    input  logic                       in_valid,
    input  logic [NN*DATA_WIDTH-1:0]   in_data,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       drop,
    output logic [7:0]                 drop_cnt
);

`ifdef LAYER_BRIDGE_PINGPONG_EN
    localparam int c_NSLOT = 2;
`else
    localparam int c_NSLOT = 1;
`endif
    localparam int                    c_BEAT_W    = beat_width(NN);
    localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT = c_BEAT_W'(NN - 1);

    slot_state_t               r_state     [c_NSLOT];
    slot_state_t               w_state_nxt [c_NSLOT];
    logic [DATA_WIDTH-1:0]     w_head      [c_NSLOT];
    logic [c_NSLOT-1:0]        w_load;
    logic [c_NSLOT-1:0]        w_shift;
    logic [NN*DATA_WIDTH-1:0]  w_load_data;

    logic                      r_rd_ptr, w_rd_ptr_nxt;
    logic                      r_wr_ptr, w_wr_ptr_nxt;
    logic [c_BEAT_W-1:0]       r_beat, w_beat_nxt;
    logic [DATA_WIDTH-1:0]     r_out_data, w_out_data_nxt;
    logic                      r_out_valid, w_out_valid_nxt;
    logic                      r_out_last;
    logic                      r_drop;
    logic [7:0]                r_drop_cnt;

    slot_state_t               w_wr_state, w_other_state;
    logic [DATA_WIDTH-1:0]     w_rd_head, w_other_head;
    logic                      w_xfer, w_last_xfer, w_accept, w_start_other, w_direct;
    logic                      w_busy;

    // Slot storage, one shift buffer per slot
    for (genvar g = 0; g < c_NSLOT; g++) begin : g_slot
        vec_shift_buf #(
            .NN         (NN),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_buf (
            .clk         (clk),
            .rst         (wb_rst_i),
            .i_load      (w_load[g]),
            .i_load_data (w_load_data),
            .i_shift     (w_shift[g]),
            .o_head      (w_head[g])
        );
    end

    // Look up the read slot, the write slot and the slot queued behind the read slot
    always_comb begin
        w_wr_state    = SLOT_EMPTY;
        w_other_state = SLOT_EMPTY;
        w_rd_head     = '0;
        w_other_head  = '0;
        w_busy        = 1'b0;
        for (int i = 0; i < c_NSLOT; i++) begin
            if (i == int'(r_rd_ptr)) begin
                w_rd_head = w_head[i];
            end else begin
                w_other_state = r_state[i];
                w_other_head  = w_head[i];
            end
            if (i == int'(r_wr_ptr)) begin
                w_wr_state = r_state[i];
            end
            if (r_state[i] != SLOT_EMPTY) begin
                w_busy = 1'b1;
            end
        end
    end

    // Handshake decode: a capture is accepted if the write slot is empty or
    // is the slot whose final beat leaves this very cycle
    always_comb begin
        w_xfer        = r_out_valid & out_ready;
        w_last_xfer   = w_xfer & r_out_last;
        w_accept      = in_valid & ((w_wr_state == SLOT_EMPTY) ||
                                    ((r_wr_ptr == r_rd_ptr) && w_last_xfer));
        w_start_other = w_last_xfer && (w_other_state == SLOT_FULL);
        w_direct      = w_accept && !w_start_other && (!r_out_valid || w_last_xfer);
    end

    // Next-state for slots, pointers, beat counter and output register
    always_comb begin
        w_load          = '0;
        w_shift         = '0;
        w_load_data     = in_data;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_beat_nxt      = r_beat;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        for (int i = 0; i < c_NSLOT; i++) begin
            w_state_nxt[i] = r_state[i];
        end

        // Mid-vector transfer: present the next element of the read slot
        if (w_xfer && !r_out_last) begin
            w_out_data_nxt = w_rd_head;
            w_beat_nxt     = r_beat + 1'b1;
            for (int i = 0; i < c_NSLOT; i++) begin
                if (i == int'(r_rd_ptr)) w_shift[i] = 1'b1;
            end
        end

        // Final beat leaves: retire the read slot
        if (w_last_xfer) begin
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = '0;
            w_beat_nxt      = '0;
            for (int i = 0; i < c_NSLOT; i++) begin
                if (i == int'(r_rd_ptr)) w_state_nxt[i] = SLOT_EMPTY;
            end
        end

        // Buffered vector takes over with no bubble
        if (w_start_other) begin
            w_out_data_nxt  = w_other_head;
            w_out_valid_nxt = 1'b1;
            w_rd_ptr_nxt    = (c_NSLOT == 2) ? ~r_rd_ptr : 1'b0;
            for (int i = 0; i < c_NSLOT; i++) begin
                if (i != int'(r_rd_ptr)) begin
                    w_state_nxt[i] = SLOT_SENDING;
                    w_shift[i]     = 1'b1;
                end
            end
        end

        // Capture; element 0 goes straight to the output when nothing is ahead of it
        if (w_accept) begin
            w_wr_ptr_nxt = (c_NSLOT == 2) ? ~r_wr_ptr : 1'b0;
            if (w_direct) begin
                w_load_data     = in_data >> DATA_WIDTH;
                w_out_data_nxt  = in_data[DATA_WIDTH-1:0];
                w_out_valid_nxt = 1'b1;
                w_beat_nxt      = '0;
                w_rd_ptr_nxt    = r_wr_ptr;
            end
            for (int i = 0; i < c_NSLOT; i++) begin
                if (i == int'(r_wr_ptr)) begin
                    w_load[i]      = 1'b1;
                    w_state_nxt[i] = w_direct ? SLOT_SENDING : SLOT_FULL;
                end
            end
        end
    end

    // Registered state and outputs
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            for (int i = 0; i < c_NSLOT; i++) begin
                r_state[i] <= SLOT_EMPTY;
            end
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_beat      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            for (int i = 0; i < c_NSLOT; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_beat      <= w_beat_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_valid_nxt && (w_beat_nxt == c_LAST_BEAT);
        end
    end

    // Drop pulse and saturating drop counter
    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_drop <= in_valid & ~w_accept;
            if (in_valid && !w_accept && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = w_busy;
    assign drop      = r_drop;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
